vedic_mac_pipe: RTL and testbench
=================================

VEDIC_MAC_PIPE -- requirements
Module: vedic_mac_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand width N; even, >= 4.
REQ-002 SHALL have parameter ACC_GUARD, default 4: accumulator guard bits; accumulator width ACC_W = 2N+ACC_GUARD.
REQ-003 SHALL have one clock, clk; reset is asynchronous and active-high, rst.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  async active-high reset.
REQ-006 SHALL have port inData_A  in  N  operand A.
REQ-007 SHALL have port inData_B  in  N  operand B.
REQ-008 SHALL have port inSigned  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port inAccum  in  1  1 = add product to accumulator, 0 = plain product.
REQ-010 SHALL have port inClear  in  1  with inAccum=1, accumulator restarts from this product.
REQ-011 SHALL have port inValid  in  1  input beat valid.
REQ-012 SHALL have port inReady  out  1  block accepts beat.
REQ-013 SHALL have port outData_C  out  ACC_W  result; sign-extended when inSigned=1, zero-extended otherwise.
REQ-014 SHALL have port outOvf  out  1  sticky accumulator overflow.
REQ-015 SHALL have port outValid  out  1  result valid.
REQ-016 SHALL have port outReady  in  1  downstream accepts result.

Function
REQ-017 Transfer SHALL occur on a rising edge when inValid & inReady; output handoff SHALL occur when outValid & outReady.
REQ-018 Pipeline SHALL have three register stages and a fixed latency of 3 cycles from input transfer to outValid, with no stall.
- S1: register operands and control; in signed mode, register magnitudes |A| and |B| (N bits unsigned; -2^(N-1) maps to 2^(N-1)) and result sign = sA^sB.
- S2: register four (N/2)x(N/2) Vedic partial products (hi*hi, lo*hi, hi*lo, lo*lo).
- S3: combine as (hh<<N) + ((hl+lh)<<N/2) + ll to the 2N-bit magnitude; negate when the sign bit is set; extend to ACC_W; apply the accumulate step; register the result.
REQ-019 Pipeline SHALL advance as a whole on adv = ~outValid | outReady; inReady SHALL equal adv; all stages SHALL hold while adv=0; a bubble SHALL propagate as stage-valid=0.
REQ-020 Accumulate step: inAccum=0 SHALL give acc unchanged and out = product; inAccum=1 and inClear=1 SHALL give acc = product; inAccum=1 and inClear=0 SHALL give acc = acc + product. Out SHALL equal the new acc in both accumulate cases.
REQ-021 Accumulator SHALL wrap modulo 2^ACC_W.
REQ-022 outOvf SHALL set on signed overflow in signed mode, or carry-out in unsigned mode, during any accumulate add. It SHALL clear only on reset or on an accumulate beat with inClear=1, in which case it takes that beat's overflow (always 0).
REQ-023 The accumulator SHALL update only when the S3 beat actually advances, so a stalled beat is never added twice.
REQ-024 Back-to-back beats SHALL give a throughput of 1 result/cycle when outReady=1.
REQ-025 Mixed signed/unsigned beats SHALL be legal; each beat SHALL use its own inSigned.

Reset
REQ-026 On rst=1, all stage valids, outValid, outData_C, outOvf and the accumulator SHALL go to 0 immediately; inReady SHALL be 1.
REQ-027 Beats in flight during reset SHALL be discarded; the first post-reset accumulate SHALL act as if inClear=1 was issued with acc=0.

Structure
REQ-028 A shared package/include SHALL hold the DATA_WIDTH default, the ACC_GUARD default, the pipeline-latency constant (3) and the ACC_W derivation.
REQ-029 A single combinational sub-module, vedic_mult_half, SHALL provide the parametrised (N/2)x(N/2) unsigned Vedic product; it SHALL be instantiated four times in S2.

Verification
REQ-030 Unsigned, N=8: A=255, B=255, inAccum=0 -> outData_C=65025 after exactly 3 cycles.
REQ-031 Signed: A=-128, B=-128 -> 16384; A=-128, B=127 -> -16256 (sign-extended).
REQ-032 MAC: ten beats A=i, B=i for i=1..10, first beat inClear=1 -> final out 385, outOvf=0.
REQ-033 Overflow: signed accumulate of 16384 x 64 (ACC_W=20) -> wraps, outOvf=1; next inClear beat -> outOvf=0.
REQ-034 Backpressure: stream 5 accumulate beats, hold outReady=0 for 4 cycles mid-stream -> inReady=0, outputs held stable, sum counted once.
REQ-035 Reset mid-stream: assert rst with 3 beats in flight -> outValid=0 at once; no stale beat emerges after release.

Source files
------------

// File: rtl/vedic_mac_pipe_pkg.sv
// Shared constants and types for the Vedic multiply-accumulate pipeline.
//   DATA_WIDTH_DEF : default operand width N
//   ACC_GUARD_DEF  : default accumulator guard bits
//   PIPE_LAT       : register stages from input transfer to outValid
//   acc_width()    : accumulator width, 2N + guard bits
package vedic_mac_pipe_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_GUARD_DEF  = 4;
  localparam int PIPE_LAT       = 3;

  function automatic int acc_width(input int n, input int guard);
    return 2 * n + guard;
  endfunction

  // Per-beat control that travels down the pipe alongside the data.
  typedef struct packed {
    logic sgn;    // two's-complement beat
    logic accum;  // add into accumulator
    logic clear;  // restart accumulator from this product
  } beat_ctrl_t;

endpackage

// File: rtl/vedic_mult_half.sv
// Combinational unsigned HALF_W x HALF_W multiplier, Urdhva-Tiryagbhyam
// (vertical and crosswise) style: every output column k is the sum of all
// bit products a[i]&b[j] with i+j==k plus the carry out of column k-1.
//   a, b : HALF_W-bit unsigned operands
//   p    : 2*HALF_W-bit unsigned product
module vedic_mult_half #(
  parameter int HALF_W = 4
) (
  input  logic [HALF_W-1:0]   a,
  input  logic [HALF_W-1:0]   b,
  output logic [2*HALF_W-1:0] p
);

  localparam int PW = 2 * HALF_W;

  // Column sum plus incoming carry never exceeds PW bits.
  logic [PW-1:0] col;
  logic [PW-1:0] carry;

  always_comb begin
    p     = '0;
    col   = '0;
    carry = '0;
    for (int k = 0; k < PW; k++) begin
      col = carry;
      for (int i = 0; i < HALF_W; i++) begin
        for (int j = 0; j < HALF_W; j++) begin
          if (i + j == k) col = col + {{(PW-1){1'b0}}, a[i] & b[j]};
        end
      end
      p[k]  = col[0];
      carry = col >> 1;
    end
  end

endmodule

// File: rtl/vedic_mac_pipe.sv
// Three-stage pipelined Vedic multiply-accumulate.
//   S1: operand magnitudes, product sign, beat control
//   S2: four half-width Vedic partial products
//   S3: recombine, apply sign, extend, accumulate, register result
// Ports:
//   clk, rst               : rising-edge clock, async active-high reset
//   inData_A, inData_B     : N-bit operands
//   inSigned               : 1 = two's-complement beat
//   inAccum, inClear       : accumulate / restart-accumulator controls
//   inValid, inReady       : input handshake (inReady = pipeline advance)
//   outData_C              : ACC_W-bit result
//   outOvf                 : sticky accumulator overflow
//   outValid, outReady     : output handshake
module vedic_mac_pipe
  import vedic_mac_pipe_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int ACC_GUARD  = ACC_GUARD_DEF,
  localparam int ACC_W      = acc_width(DATA_WIDTH, ACC_GUARD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inData_A,
  input  logic [DATA_WIDTH-1:0] inData_B,
  input  logic                  inSigned,
  input  logic                  inAccum,
  input  logic                  inClear,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [ACC_W-1:0]      outData_C,
  output logic                  outOvf,
  output logic                  outValid,
  input  logic                  outReady
);

  localparam int N = DATA_WIDTH;
  localparam int H = N / 2;
  localparam int P = 2 * N;

  // ---------------- handshake / valid shift register ----------------
  logic              adv;
  logic [PIPE_LAT:1] vld_q;
  logic [PIPE_LAT:0] vld_pipe;

  assign vld_pipe = {vld_q, inValid};
  assign outValid = vld_pipe[PIPE_LAT];
  // The whole pipe moves together; a full output that is not being taken
  // freezes every stage, which also freezes the accumulator.
  assign adv      = ~outValid | outReady;
  assign inReady  = adv;

  // ---------------- S1: sign / magnitude ----------------
  logic         a_neg, b_neg;
  logic [N-1:0] a_mag, b_mag;
  beat_ctrl_t   in_ctrl;

  // Negating -2^(N-1) in N bits yields 2^(N-1) read as unsigned.
  assign a_neg   = inSigned & inData_A[N-1];
  assign b_neg   = inSigned & inData_B[N-1];
  assign a_mag   = a_neg ? -inData_A : inData_A;
  assign b_mag   = b_neg ? -inData_B : inData_B;
  assign in_ctrl = '{sgn: inSigned, accum: inAccum, clear: inClear};

  logic [N-1:0] s1_a, s1_b;
  logic         s1_neg;
  beat_ctrl_t   s1_ctrl;

  // ---------------- S2: Vedic partial products ----------------
  // Index 3 = hi*hi, 2 = lo*hi, 1 = hi*lo, 0 = lo*lo (A term first).
  logic [3:0][H-1:0] pp_a, pp_b;
  logic [3:0][N-1:0] pp_c;
  logic [3:0][N-1:0] s2_pp;
  logic              s2_neg;
  beat_ctrl_t        s2_ctrl;

  assign pp_a = {s1_a[N-1:H], s1_a[H-1:0], s1_a[N-1:H], s1_a[H-1:0]};
  assign pp_b = {s1_b[N-1:H], s1_b[N-1:H], s1_b[H-1:0], s1_b[H-1:0]};

  for (genvar g = 0; g < 4; g++) begin : g_pp
    vedic_mult_half #(.HALF_W(H)) u_mult (
      .a (pp_a[g]),
      .b (pp_b[g]),
      .p (pp_c[g])
    );
  end

  // ---------------- S3: recombine + accumulate ----------------
  logic [P-1:0]     hh_w, mid_w, ll_w, mag, prod;
  logic [ACC_W-1:0] ext, acc, acc_n, out_n;
  logic [ACC_W:0]   sum;
  logic             add_ovf, ovf_n;

  assign hh_w  = {s2_pp[3], {N{1'b0}}};
  assign mid_w = ({{N{1'b0}}, s2_pp[2]} + {{N{1'b0}}, s2_pp[1]}) << H;
  assign ll_w  = {{N{1'b0}}, s2_pp[0]};
  assign mag   = hh_w + mid_w + ll_w;
  assign prod  = s2_neg ? -mag : mag;
  assign ext   = s2_ctrl.sgn ? {{ACC_GUARD{prod[P-1]}}, prod}
                             : {{ACC_GUARD{1'b0}}, prod};

  assign sum = {1'b0, acc} + {1'b0, ext};

  // Overflow rule follows the beat's own signedness.
  always_comb begin
    if (s2_ctrl.sgn)
      add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    else
      add_ovf = sum[ACC_W];
  end

  always_comb begin
    acc_n = acc;
    ovf_n = outOvf;
    out_n = ext;
    if (s2_ctrl.accum) begin
      if (s2_ctrl.clear) begin
        acc_n = ext;
        ovf_n = 1'b0;
      end else begin
        acc_n = sum[ACC_W-1:0];
        ovf_n = outOvf | add_ovf;
      end
      out_n = acc_n;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_neg    <= 1'b0;
      s1_ctrl   <= '0;
      s2_pp     <= '0;
      s2_neg    <= 1'b0;
      s2_ctrl   <= '0;
      acc       <= '0;
      outData_C <= '0;
      outOvf    <= 1'b0;
    end else if (adv) begin
      vld_q   <= vld_pipe[PIPE_LAT-1:0];
      s1_a    <= a_mag;
      s1_b    <= b_mag;
      s1_neg  <= a_neg ^ b_neg;
      s1_ctrl <= in_ctrl;
      s2_pp   <= pp_c;
      s2_neg  <= s1_neg;
      s2_ctrl <= s1_ctrl;
      // Only a real beat leaving S2 touches the result and accumulator.
      if (vld_pipe[2]) begin
        acc       <= acc_n;
        outData_C <= out_n;
        outOvf    <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mac_pipe.sv
// Directed bench for vedic_mac_pipe (N=8, ACC_W=20).
module tb_vedic_mac_pipe;

  logic        clk, rst;
  logic [7:0]  inData_A, inData_B;
  logic        inSigned, inAccum, inClear, inValid, inReady;
  logic [19:0] outData_C;
  logic        outOvf, outValid, outReady;

  int n_pass = 0;
  int n_total = 0;

  logic [19:0] res_q[$];
  logic        ovf_q[$];

  vedic_mac_pipe #(.DATA_WIDTH(8), .ACC_GUARD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .inData_A  (inData_A),
    .inData_B  (inData_B),
    .inSigned  (inSigned),
    .inAccum   (inAccum),
    .inClear   (inClear),
    .inValid   (inValid),
    .inReady   (inReady),
    .outData_C (outData_C),
    .outOvf    (outOvf),
    .outValid  (outValid),
    .outReady  (outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every result that is handed off at the next rising edge.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      res_q.push_back(outData_C);
      ovf_q.push_back(outOvf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present one beat and hold it until the block accepts it.
  task automatic beat(input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic acc, input logic clr);
    logic ok;
    int   cyc;
    inData_A = a; inData_B = b; inSigned = s; inAccum = acc; inClear = clr;
    inValid  = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      ok = inReady;
      @(posedge clk);
      cyc++;
    end while (!ok && cyc < 50);
    #1;
    inValid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL beat_accept: inReady stayed low for %0d cycles, required 1", cyc);
    end
  endtask

  task automatic wait_results(input int n);
    int cyc = 0;
    while (res_q.size() < n && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (res_q.size() < n) begin
      n_total++;
      $display("FAIL result_count: got %0d results, required %0d", res_q.size(), n);
    end
  endtask

  task automatic flush();
    repeat (5) @(posedge clk);
    #1;
    res_q.delete();
    ovf_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (outValid !== 1'b0) $display("FAIL rst_outValid: got %b required 0", outValid); else n_pass++;
    n_total++; if (outData_C !== 20'd0) $display("FAIL rst_outData: got %0h required 0", outData_C); else n_pass++;
    n_total++; if (outOvf !== 1'b0) $display("FAIL rst_outOvf: got %b required 0", outOvf); else n_pass++;
    n_total++; if (inReady !== 1'b1) $display("FAIL rst_inReady: got %b required 1", inReady); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    flush();
    inData_A = 8'd255; inData_B = 8'd255; inSigned = 1'b0; inAccum = 1'b0;
    inClear = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    n_total++; if (outValid !== 1'b0) $display("FAIL lat_cycle1: outValid %b required 0", outValid); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (outValid !== 1'b0) $display("FAIL lat_cycle2: outValid %b required 0", outValid); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (outValid !== 1'b1) $display("FAIL lat_cycle3: outValid %b required 1", outValid); else n_pass++;
    n_total++; if (outData_C !== 20'd65025) $display("FAIL lat_data: got %0d required 65025", outData_C); else n_pass++;
  endtask

  task automatic test_signed();
    logic [19:0] exp [5];
    exp[0] = 20'd16384;   // -128 * -128
    exp[1] = 20'hFC080;   // -128 * 127 = -16256
    exp[2] = 20'hFFFF1;   // -3 * 5 = -15
    exp[3] = 20'd32640;   // unsigned 128 * 255
    exp[4] = 20'd128;     // signed -128 * -1
    flush();
    beat(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    beat(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
    beat(8'hFD, 8'h05, 1'b1, 1'b0, 1'b0);
    beat(8'h80, 8'hFF, 1'b0, 1'b0, 1'b0);
    beat(8'h80, 8'hFF, 1'b1, 1'b0, 1'b0);
    wait_results(5);
    for (int i = 0; i < 5; i++) begin
      if (i < res_q.size()) begin
        n_total++;
        if (res_q[i] !== exp[i]) $display("FAIL signed_%0d: got %0h required %0h", i, res_q[i], exp[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mac();
    logic [19:0] run;
    flush();
    for (int i = 1; i <= 10; i++) beat(8'(i), 8'(i), 1'b0, 1'b1, i == 1);
    wait_results(10);
    run = '0;
    for (int i = 0; i < 10 && i < res_q.size(); i++) begin
      run = run + 20'((i + 1) * (i + 1));
      n_total++;
      if (res_q[i] !== run) $display("FAIL mac_step%0d: got %0d required %0d", i, res_q[i], run);
      else n_pass++;
    end
    n_total++; if (outData_C !== 20'd385) $display("FAIL mac_final: got %0d required 385", outData_C); else n_pass++;
    n_total++; if (outOvf !== 1'b0) $display("FAIL mac_ovf: got %b required 0", outOvf); else n_pass++;
  endtask

  task automatic test_overflow();
    flush();
    for (int i = 0; i < 64; i++) beat(8'h80, 8'h80, 1'b1, 1'b1, i == 0);
    wait_results(64);
    if (res_q.size() >= 64) begin
      n_total++; if (ovf_q[30] !== 1'b0) $display("FAIL ovf_before: got %b required 0", ovf_q[30]); else n_pass++;
      n_total++; if (res_q[31] !== 20'h80000) $display("FAIL ovf_wrap: got %0h required 80000", res_q[31]); else n_pass++;
      n_total++; if (ovf_q[31] !== 1'b1) $display("FAIL ovf_set: got %b required 1", ovf_q[31]); else n_pass++;
    end
    n_total++; if (outData_C !== 20'd0) $display("FAIL ovf_final: got %0h required 0", outData_C); else n_pass++;
    n_total++; if (outOvf !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", outOvf); else n_pass++;
    flush();
    beat(8'd3, 8'd4, 1'b0, 1'b1, 1'b1);
    wait_results(1);
    n_total++; if (outData_C !== 20'd12) $display("FAIL ovf_clear_data: got %0d required 12", outData_C); else n_pass++;
    n_total++; if (outOvf !== 1'b0) $display("FAIL ovf_clear: got %b required 0", outOvf); else n_pass++;
    // Unsigned carry-out: 17 * 65025 = 1105425 wraps past 2^20.
    flush();
    for (int i = 0; i < 17; i++) beat(8'hFF, 8'hFF, 1'b0, 1'b1, i == 0);
    wait_results(17);
    if (ovf_q.size() >= 17) begin
      n_total++; if (ovf_q[15] !== 1'b0) $display("FAIL uovf_before: got %b required 0", ovf_q[15]); else n_pass++;
    end
    n_total++; if (outData_C !== 20'd56849) $display("FAIL uovf_wrap: got %0d required 56849", outData_C); else n_pass++;
    n_total++; if (outOvf !== 1'b1) $display("FAIL uovf_set: got %b required 1", outOvf); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [19:0] exp [5];
    exp[0] = 20'd2; exp[1] = 20'd6; exp[2] = 20'd12; exp[3] = 20'd20; exp[4] = 20'd30;
    flush();
    beat(8'd1, 8'd2, 1'b0, 1'b1, 1'b1);
    beat(8'd2, 8'd2, 1'b0, 1'b1, 1'b0);
    beat(8'd3, 8'd2, 1'b0, 1'b1, 1'b0);
    outReady = 1'b0;
    inData_A = 8'd4; inData_B = 8'd2; inSigned = 1'b0; inAccum = 1'b1;
    inClear = 1'b0; inValid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_total++; if (inReady !== 1'b0) $display("FAIL bp_inReady: got %b required 0", inReady); else n_pass++;
      n_total++; if (outValid !== 1'b1 || outData_C !== 20'd2)
        $display("FAIL bp_hold: got valid %b data %0d required valid 1 data 2", outValid, outData_C);
      else n_pass++;
    end
    outReady = 1'b1;
    beat(8'd4, 8'd2, 1'b0, 1'b1, 1'b0);
    beat(8'd5, 8'd2, 1'b0, 1'b1, 1'b0);
    wait_results(5);
    repeat (4) @(posedge clk);
    #1;
    n_total++; if (res_q.size() !== 5) $display("FAIL bp_count: got %0d results required 5", res_q.size()); else n_pass++;
    for (int i = 0; i < 5 && i < res_q.size(); i++) begin
      n_total++;
      if (res_q[i] !== exp[i]) $display("FAIL bp_res%0d: got %0d required %0d", i, res_q[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    flush();
    beat(8'd9, 8'd9, 1'b0, 1'b1, 1'b1);
    beat(8'd9, 8'd9, 1'b0, 1'b1, 1'b0);
    beat(8'd9, 8'd9, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    n_total++; if (outValid !== 1'b0) $display("FAIL mid_rst_valid: got %b required 0", outValid); else n_pass++;
    n_total++; if (outData_C !== 20'd0) $display("FAIL mid_rst_data: got %0d required 0", outData_C); else n_pass++;
    n_total++; if (inReady !== 1'b1) $display("FAIL mid_rst_ready: got %b required 1", inReady); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_total++; if (res_q.size() !== 0) $display("FAIL mid_stale: got %0d results required 0", res_q.size()); else n_pass++;
    beat(8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
    wait_results(1);
    n_total++; if (outData_C !== 20'd6) $display("FAIL mid_first_acc: got %0d required 6", outData_C); else n_pass++;
    n_total++; if (outOvf !== 1'b0) $display("FAIL mid_first_ovf: got %b required 0", outOvf); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; inData_A = '0; inData_B = '0; inSigned = 1'b0; inAccum = 1'b0;
    inClear = 1'b0; inValid = 1'b0; outReady = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_latency();
    test_signed();
    test_mac();
    test_overflow();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
